// File: rtl/hart_pc_scheduler.sv
// hart_pc_scheduler
//   Per-hart program-counter file with a round-robin fetch scheduler for a
//   barrel-threaded front end. One PC and one active bit per thread; each
//   cycle one thread slot is offered to instruction fetch. The PC of the
//   fetched thread auto-increments by 4. The back end can redirect a PC and
//   halt or wake a thread, including while the front end is stalled.
//
//   Optional feature macro: HART_PC_SKIP_IDLE_EN
//     defined   : the scheduler skips inactive threads. It holds if no thread is active.
//     undefined : strict rotation. An inactive thread's slot is a bubble.
//
// Ports
//   clk, reset          : clock; asynchronous active-high reset
//   stall               : freezes scheduling and PC auto-increment
//   redirect_valid/tid/pc : overwrite one thread's PC (bits [1:0] cleared)
//   halt_valid/tid      : deactivate a thread (wins over wake on same tid)
//   wake_valid/tid      : activate a thread
//   fetch_valid/tid/pc  : fetch request for the current thread slot
//   active_mask         : per-thread active bits
module hart_pc_scheduler #(
    parameter int unsigned NTHREADS = 5,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned BASE     = 0,
    parameter int unsigned STRIDE   = 400,
    parameter int unsigned TID_W    = $clog2(NTHREADS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [TID_W-1:0]    redirect_tid,
    input  logic [WIDTH-1:0]    redirect_pc,
    input  logic                halt_valid,
    input  logic [TID_W-1:0]    halt_tid,
    input  logic                wake_valid,
    input  logic [TID_W-1:0]    wake_tid,
    output logic                fetch_valid,
    output logic [TID_W-1:0]    fetch_tid,
    output logic [WIDTH-1:0]    fetch_pc,
    output logic [NTHREADS-1:0] active_mask
);

    logic [WIDTH-1:0]    pc_q [NTHREADS];
    logic [WIDTH-1:0]    pc_d [NTHREADS];
    logic [NTHREADS-1:0] active_q, active_d;
    logic [TID_W-1:0]    cur_tid_q, cur_tid_d;

    // Reset PC of thread i, wrapping modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] reset_pc(input int unsigned i);
        return WIDTH'(BASE) + WIDTH'(i) * WIDTH'(STRIDE);
    endfunction

    assign fetch_tid   = cur_tid_q;
    assign fetch_pc    = pc_q[cur_tid_q];
    assign fetch_valid = active_q[cur_tid_q] & ~stall;
    assign active_mask = active_q;

    // PC file: increment of the issuing thread first, redirect second so a
    // redirect to the same thread overrides the +4.
    always_comb begin
        for (int unsigned i = 0; i < NTHREADS; i++) begin
            pc_d[i] = pc_q[i];
        end
        if (fetch_valid) begin
            pc_d[cur_tid_q] = pc_q[cur_tid_q] + WIDTH'(4);
        end
        if (redirect_valid && (32'(redirect_tid) < NTHREADS)) begin
            pc_d[redirect_tid] = redirect_pc & ~WIDTH'(3);
        end
    end

    // Active bits: wake applied before halt so halt wins on a tie.
    always_comb begin
        active_d = active_q;
        if (wake_valid && (32'(wake_tid) < NTHREADS)) begin
            active_d[wake_tid] = 1'b1;
        end
        if (halt_valid && (32'(halt_tid) < NTHREADS)) begin
            active_d[halt_tid] = 1'b0;
        end
    end

`ifdef HART_PC_SKIP_IDLE_EN
    logic        found;
    int unsigned idx;

    // Scan cur+1 .. cur+NTHREADS (cur itself last) against the post-update
    // active bits; first hit wins, otherwise hold.
    always_comb begin
        cur_tid_d = cur_tid_q;
        found     = 1'b0;
        idx       = 0;
        if (!stall) begin
            for (int unsigned k = 1; k <= NTHREADS; k++) begin
                idx = 32'(cur_tid_q) + k;
                if (idx >= NTHREADS) begin
                    idx = idx - NTHREADS;
                end
                if (!found && active_d[TID_W'(idx)]) begin
                    cur_tid_d = TID_W'(idx);
                    found     = 1'b1;
                end
            end
        end
    end
`else
    always_comb begin
        cur_tid_d = cur_tid_q;
        if (!stall) begin
            if (cur_tid_q == TID_W'(NTHREADS - 1)) begin
                cur_tid_d = '0;
            end else begin
                cur_tid_d = cur_tid_q + 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NTHREADS; i++) begin
                pc_q[i] <= reset_pc(i);
            end
            active_q  <= '1;
            cur_tid_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NTHREADS; i++) begin
                pc_q[i] <= pc_d[i];
            end
            active_q  <= active_d;
            cur_tid_q <= cur_tid_d;
        end
    end

endmodule

// File: tb/tb_hart_pc_scheduler.sv
// tb_hart_pc_scheduler
//   Directed bench for hart_pc_scheduler with default parameters. Stimulus
//   queues the expected per-cycle outputs; a negedge monitor pops and checks.
//   Expectations for halted-thread scheduling follow HART_PC_SKIP_IDLE_EN.
module tb_hart_pc_scheduler;

    localparam int unsigned NT = 5;
    localparam int unsigned W  = 32;
    localparam int unsigned TW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          stall;
    logic          redirect_valid;
    logic [TW-1:0] redirect_tid;
    logic [W-1:0]  redirect_pc;
    logic          halt_valid;
    logic [TW-1:0] halt_tid;
    logic          wake_valid;
    logic [TW-1:0] wake_tid;
    logic          fetch_valid;
    logic [TW-1:0] fetch_tid;
    logic [W-1:0]  fetch_pc;
    logic [NT-1:0] active_mask;

    hart_pc_scheduler #(
        .NTHREADS(5),
        .WIDTH(32),
        .BASE(0),
        .STRIDE(400)
    ) dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect_valid(redirect_valid),
        .redirect_tid(redirect_tid),
        .redirect_pc(redirect_pc),
        .halt_valid(halt_valid),
        .halt_tid(halt_tid),
        .wake_valid(wake_valid),
        .wake_tid(wake_tid),
        .fetch_valid(fetch_valid),
        .fetch_tid(fetch_tid),
        .fetch_pc(fetch_pc),
        .active_mask(active_mask)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            id;
        logic          v;
        logic [TW-1:0] tid;
        logic [W-1:0]  pc;
        logic [NT-1:0] mask;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_id   = 0;

    task automatic expect_out(input logic v, input int tid, input logic [W-1:0] pc,
                              input logic [NT-1:0] mask);
        exp_t e;
        e.id   = n_id;
        e.v    = v;
        e.tid  = TW'(tid);
        e.pc   = pc;
        e.mask = mask;
        n_id++;
        sb.push_back(e);
    endtask

    // Expect outputs for the current cycle, then advance one clock and drop
    // the single-cycle request pulses.
    task automatic step(input logic v, input int tid, input logic [W-1:0] pc,
                        input logic [NT-1:0] mask);
        expect_out(v, tid, pc, mask);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        halt_valid     = 1'b0;
        wake_valid     = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_tid   = '0;
        redirect_pc    = '0;
        halt_valid     = 1'b0;
        halt_tid       = '0;
        wake_valid     = 1'b0;
        wake_tid       = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic halt(input int t);
        halt_valid = 1'b1;
        halt_tid   = TW'(t);
    endtask

    task automatic wake(input int t);
        wake_valid = 1'b1;
        wake_tid   = TW'(t);
    endtask

    task automatic redirect(input int t, input logic [W-1:0] pc);
        redirect_valid = 1'b1;
        redirect_tid   = TW'(t);
        redirect_pc    = pc;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (fetch_valid !== e.v || fetch_tid !== e.tid || fetch_pc !== e.pc ||
                active_mask !== e.mask) begin
                errors++;
                $display("FAIL out#%0d: got v=%0b tid=%0d pc=%h mask=%b, expected v=%0b tid=%0d pc=%h mask=%b",
                         e.id, fetch_valid, fetch_tid, fetch_pc, active_mask,
                         e.v, e.tid, e.pc, e.mask);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Round-robin from reset, plus out-of-range redirect/halt ignored.
        do_reset();
        step(1, 0, 0, 5'b11111);
        redirect(5, 32'h888);
        halt(6);
        step(1, 1, 400, 5'b11111);
        step(1, 2, 800, 5'b11111);
        step(1, 3, 1200, 5'b11111);
        step(1, 4, 1600, 5'b11111);
        step(1, 0, 4, 5'b11111);
        step(1, 1, 404, 5'b11111);

        // Redirect overrides the +4 of the issuing thread.
        do_reset();
        step(1, 0, 0, 5'b11111);
        step(1, 1, 400, 5'b11111);
        redirect(2, 32'h1000);
        step(1, 2, 800, 5'b11111);
        step(1, 3, 1200, 5'b11111);
        step(1, 4, 1600, 5'b11111);
        step(1, 0, 4, 5'b11111);
        step(1, 1, 404, 5'b11111);
        step(1, 2, 32'h1000, 5'b11111);

        // Stall for 3 cycles at tid 1 with a redirect of tid 3.
        do_reset();
        step(1, 0, 0, 5'b11111);
        stall = 1'b1;
        redirect(3, 32'h40);
        step(0, 1, 400, 5'b11111);
        step(0, 1, 400, 5'b11111);
        step(0, 1, 400, 5'b11111);
        stall = 1'b0;
        step(1, 1, 400, 5'b11111);
        step(1, 2, 800, 5'b11111);
        step(1, 3, 32'h40, 5'b11111);

        // Halt tids 1 and 3 right after reset.
        do_reset();
        halt(1);
        step(1, 0, 0, 5'b11111);
        halt(3);
`ifdef HART_PC_SKIP_IDLE_EN
        step(1, 2, 800, 5'b11101);
        step(1, 4, 1600, 5'b10101);
        step(1, 0, 4, 5'b10101);
        step(1, 2, 804, 5'b10101);
`else
        step(0, 1, 400, 5'b11101);
        step(1, 2, 800, 5'b10101);
        step(0, 3, 1200, 5'b10101);
        step(1, 4, 1600, 5'b10101);
        step(1, 0, 4, 5'b10101);
`endif

`ifdef HART_PC_SKIP_IDLE_EN
        // Halt every thread, wake one, then halt+wake the same tid.
        do_reset();
        halt(4);
        step(1, 0, 0, 5'b11111);
        halt(0);
        step(1, 1, 400, 5'b01111);
        halt(1);
        step(1, 2, 800, 5'b01110);
        halt(2);
        step(1, 3, 1200, 5'b01100);
        halt(3);
        step(1, 3, 1204, 5'b01000);
        step(0, 3, 1208, 5'b00000);
        wake(4);
        step(0, 3, 1208, 5'b00000);
        halt(4);
        wake(4);
        step(1, 4, 1600, 5'b10000);
        step(0, 4, 1604, 5'b00000);
        step(0, 4, 1604, 5'b00000);
`else
        // Halt+wake the same tid: halt wins; a later wake restores the slot.
        do_reset();
        halt(2);
        wake(2);
        step(1, 0, 0, 5'b11111);
        step(1, 1, 400, 5'b11011);
        step(0, 2, 800, 5'b11011);
        wake(2);
        step(1, 3, 1200, 5'b11011);
        step(1, 4, 1600, 5'b11111);
        step(1, 0, 4, 5'b11111);
        step(1, 1, 404, 5'b11111);
        step(1, 2, 800, 5'b11111);
`endif

        // Low PC bits cleared on redirect, wrap on +4, asynchronous reset.
        do_reset();
        redirect(0, 32'hFFFF_FFFE);
        step(1, 0, 0, 5'b11111);
        step(1, 1, 400, 5'b11111);
        step(1, 2, 800, 5'b11111);
        step(1, 3, 1200, 5'b11111);
        step(1, 4, 1600, 5'b11111);
        step(1, 0, 32'hFFFF_FFFC, 5'b11111);
        step(1, 1, 404, 5'b11111);
        step(1, 2, 804, 5'b11111);
        step(1, 3, 1204, 5'b11111);
        step(1, 4, 1604, 5'b11111);
        step(1, 0, 32'h0000_0000, 5'b11111);
        halt(2);
        redirect(3, 32'h500);
        reset = 1'b1;
        expect_out(1, 0, 0, 5'b11111);
        @(negedge clk);
        #1;
        @(posedge clk);
        #1;
        reset          = 1'b0;
        redirect_valid = 1'b0;
        halt_valid     = 1'b0;
        step(1, 0, 0, 5'b11111);
        step(1, 1, 400, 5'b11111);
        step(1, 2, 800, 5'b11111);
        step(1, 3, 1200, 5'b11111);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
